div_measure: RTL and testbench

- Inverse of the PIO clock divider. Samples an external or divided clock-like signal on `pin` and recovers its period and high time, counted in `clk` cycles.
- Period is measured rising edge to rising edge; high time is measured rising edge to falling edge.
- A lock flag is raised once the period is stable. The block sits beside the divider for self-test, and on GPIO inputs to measure incoming clocks for PIO clock recovery.

---
 rtl/div_measure.sv | 116 +++++++++++
 tb/tb_div_measure.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_measure.sv
// Clock period / high-time meter for the PIO divider.
// Counts clk cycles between synchronized pin edges and flags lock.
module div_measure #(
  parameter int W          = 24,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         pin,
  output logic [W-1:0] period,
  output logic [W-1:0] high,
  output logic         valid,
  output logic         locked,
  output logic         overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam logic [W-1:0] CMAX = '1;
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  localparam logic signed [W:0] TOLV = (W+1)'(TOL);

  state_t state;
  logic s1, s2, s3;
  logic rise, fall;
  logic [W-1:0] cnt;
  logic [3:0] mcnt;
  logic [3:0] mnext;
  logic fresh;
  logic signed [W:0] diff;
  logic signed [W:0] adiff;
  logic match;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  assign diff = $signed({1'b0, cnt})
              - $signed({1'b0, period});
  assign adiff = diff[W] ? -diff : diff;
  // first period after arming compares against a stale value
  assign match = !fresh && (adiff <= TOLV);
  assign mnext = (mcnt >= LC) ? LC : mcnt + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      period   <= '0;
      high     <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      overflow <= 1'b0;
      mcnt     <= '0;
      fresh    <= 1'b0;
    end else begin
      s1       <= pin;
      s2       <= s1;
      s3       <= s2;
      valid    <= 1'b0;
      overflow <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
        mcnt   <= '0;
        cnt    <= '0;
        fresh  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              cnt   <= W'(1);
              fresh <= 1'b1;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period <= cnt;
              cnt    <= W'(1);
              valid  <= 1'b1;
              fresh  <= 1'b0;
              if (match) begin
                mcnt   <= mnext;
                locked <= (mnext == LC);
              end else begin
                mcnt   <= '0;
                locked <= 1'b0;
              end
            end else if (cnt == CMAX) begin
              overflow <= 1'b1;
              locked   <= 1'b0;
              mcnt     <= '0;
              cnt      <= '0;
              state    <= ARM;
            end else begin
              cnt <= cnt + W'(1);
              if (fall) high <= cnt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_measure.sv
// Directed bench for div_measure.
// Two instances: TOL=0 (u0) and TOL=1 (u1), both W=8.
module tb_div_measure;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic pin = 1'b0;
  logic [7:0] period0, high0, period1, high1;
  logic valid0, locked0, ovf0;
  logic valid1, locked1, ovf1;

  int checks = 0;
  int errors = 0;
  int per_q[$];
  int hi_q[$];
  int lk_q[$];
  int vt_q[$];
  int rt_q[$];
  int ovf_n = 0;
  int ovf_t = 0;
  int tcnt = 0;
  int rise_t = 0;
  bit ever0 = 1'b0;

  always #5 clk = ~clk;

  div_measure #(.W(8), .LOCK_COUNT(4), .TOL(0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .pin(pin),
    .period(period0), .high(high0), .valid(valid0),
    .locked(locked0), .overflow(ovf0)
  );

  div_measure #(.W(8), .LOCK_COUNT(4), .TOL(1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .pin(pin),
    .period(period1), .high(high1), .valid(valid1),
    .locked(locked1), .overflow(ovf1)
  );

  task automatic tick(input logic p);
    @(posedge clk);
    #1;
    tcnt++;
    if (p && !pin) begin
      rise_t = tcnt;
      rt_q.push_back(tcnt);
    end
    pin = p;
    @(negedge clk);
    if (valid0) begin
      per_q.push_back(int'(period0));
      hi_q.push_back(int'(high0));
      lk_q.push_back(int'(locked0));
      vt_q.push_back(tcnt);
    end
    if (ovf0) begin
      ovf_n++;
      ovf_t = tcnt;
    end
    if (locked0) ever0 = 1'b1;
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (h) tick(1'b1);
      repeat (l) tick(1'b0);
    end
  endtask

  task automatic clr();
    per_q.delete();
    hi_q.delete();
    lk_q.delete();
    vt_q.delete();
    rt_q.delete();
    ovf_n = 0;
    ever0 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    pin = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    repeat (3) tick(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b0;
    pin = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (period0 !== 8'd0) begin
      errors++;
      $display("FAIL rst_period got %0d want 0", period0);
    end
    checks++;
    if (high0 !== 8'd0) begin
      errors++;
      $display("FAIL rst_high got %0d want 0", high0);
    end
    checks++;
    if ({valid0, locked0, ovf0} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags got %b want 000",
               {valid0, locked0, ovf0});
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({valid0, locked0, ovf0} !== 3'b000) begin
      errors++;
      $display("FAIL rst_idle_flags got %b want 000",
               {valid0, locked0, ovf0});
    end
  endtask

  task automatic test_div6();
    do_reset();
    clr();
    wave(3, 3, 6);
    checks++;
    if (per_q.size() != 5) begin
      errors++;
      $display("FAIL div6_nvalid got %0d want 5", per_q.size());
    end
    for (int k = 0; k < per_q.size(); k++) begin
      checks++;
      if (per_q[k] != 6 || hi_q[k] != 3) begin
        errors++;
        $display("FAIL div6_val[%0d] got %0d/%0d want 6/3",
                 k, per_q[k], hi_q[k]);
      end
      checks++;
      if (lk_q[k] != ((k == 4) ? 1 : 0)) begin
        errors++;
        $display("FAIL div6_lock[%0d] got %0d want %0d",
                 k, lk_q[k], (k == 4) ? 1 : 0);
      end
      if (k + 1 < rt_q.size()) begin
        checks++;
        if (vt_q[k] - rt_q[k+1] != 3) begin
          errors++;
          $display("FAIL div6_latency[%0d] got %0d want 3",
                   k, vt_q[k] - rt_q[k+1]);
        end
      end
    end
    for (int k = 0; k + 1 < vt_q.size(); k++) begin
      checks++;
      if (vt_q[k+1] - vt_q[k] != 6) begin
        errors++;
        $display("FAIL div6_spacing[%0d] got %0d want 6",
                 k, vt_q[k+1] - vt_q[k]);
      end
    end
  endtask

  task automatic test_div7_to_8();
    int ep[6];
    int el[6];
    ep = '{7, 8, 8, 8, 8, 8};
    el = '{1, 0, 0, 0, 0, 1};
    do_reset();
    clr();
    wave(4, 3, 6);
    checks++;
    if (per_q.size() != 5) begin
      errors++;
      $display("FAIL div7_nvalid got %0d want 5", per_q.size());
    end
    for (int k = 0; k < per_q.size(); k++) begin
      checks++;
      if (per_q[k] != 7 || hi_q[k] != 4) begin
        errors++;
        $display("FAIL div7_val[%0d] got %0d/%0d want 7/4",
                 k, per_q[k], hi_q[k]);
      end
    end
    checks++;
    if (locked0 !== 1'b1) begin
      errors++;
      $display("FAIL div7_locked got %b want 1", locked0);
    end
    clr();
    wave(4, 4, 6);
    checks++;
    if (per_q.size() != 6) begin
      errors++;
      $display("FAIL div8_nvalid got %0d want 6", per_q.size());
    end
    for (int k = 0; k < per_q.size() && k < 6; k++) begin
      checks++;
      if (per_q[k] != ep[k] || hi_q[k] != 4) begin
        errors++;
        $display("FAIL div8_val[%0d] got %0d/%0d want %0d/4",
                 k, per_q[k], hi_q[k], ep[k]);
      end
      checks++;
      if (lk_q[k] != el[k]) begin
        errors++;
        $display("FAIL div8_lock[%0d] got %0d want %0d",
                 k, lk_q[k], el[k]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    clr();
    wave(3, 3, 6);
    checks++;
    if (locked0 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_prelock got %b want 1", locked0);
    end
    clr();
    repeat (300) tick(1'b0);
    checks++;
    if (ovf_n != 1) begin
      errors++;
      $display("FAIL ovf_count got %0d want 1", ovf_n);
    end
    checks++;
    if (ovf_t - rise_t != 258) begin
      errors++;
      $display("FAIL ovf_time got %0d want 258", ovf_t - rise_t);
    end
    checks++;
    if (locked0 !== 1'b0 || per_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_lock_valid got %b/%0d want 0/0",
               locked0, per_q.size());
    end
    checks++;
    if (period0 !== 8'd6 || high0 !== 8'd3) begin
      errors++;
      $display("FAIL ovf_hold got %0d/%0d want 6/3",
               period0, high0);
    end
    clr();
    wave(3, 3, 3);
    checks++;
    if (per_q.size() != 2) begin
      errors++;
      $display("FAIL ovf_rearm_n got %0d want 2", per_q.size());
    end else begin
      checks++;
      if (per_q[0] != 6 || lk_q[0] != 0) begin
        errors++;
        $display("FAIL ovf_rearm got %0d/%0d want 6/0",
                 per_q[0], lk_q[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    clr();
    wave(3, 3, 6);
    tick(1'b1);
    tick(1'b1);
    checks++;
    if (locked0 !== 1'b1) begin
      errors++;
      $display("FAIL arst_prelock got %b want 1", locked0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (period0 !== 8'd0 || high0 !== 8'd0) begin
      errors++;
      $display("FAIL arst_data got %0d/%0d want 0/0",
               period0, high0);
    end
    checks++;
    if ({valid0, locked0, ovf0} !== 3'b000) begin
      errors++;
      $display("FAIL arst_flags got %b want 000",
               {valid0, locked0, ovf0});
    end
    repeat (3) tick(1'b0);
    reset = 1'b1;
    clr();
    repeat (20) tick(1'b0);
    checks++;
    if (per_q.size() != 0) begin
      errors++;
      $display("FAIL arst_quiet got %0d want 0", per_q.size());
    end
    wave(3, 3, 3);
    checks++;
    if (per_q.size() != 2) begin
      errors++;
      $display("FAIL arst_resume_n got %0d want 2", per_q.size());
    end else begin
      checks++;
      if (per_q[0] != 6 || hi_q[0] != 3) begin
        errors++;
        $display("FAIL arst_resume got %0d/%0d want 6/3",
                 per_q[0], hi_q[0]);
      end
    end
  endtask

  task automatic test_enable_toggle();
    do_reset();
    clr();
    wave(5, 5, 7);
    checks++;
    if (locked0 !== 1'b1 || per_q.size() != 6) begin
      errors++;
      $display("FAIL en_prelock got %b/%0d want 1/6",
               locked0, per_q.size());
    end
    clr();
    tick(1'b1);
    enable = 1'b0;
    repeat (3) tick(1'b1);
    enable = 1'b1;
    tick(1'b1);
    repeat (5) tick(1'b0);
    checks++;
    if (per_q.size() != 0) begin
      errors++;
      $display("FAIL en_novalid got %0d want 0", per_q.size());
    end
    checks++;
    if (locked0 !== 1'b0) begin
      errors++;
      $display("FAIL en_unlock got %b want 0", locked0);
    end
    checks++;
    if (period0 !== 8'd10 || high0 !== 8'd5) begin
      errors++;
      $display("FAIL en_hold got %0d/%0d want 10/5",
               period0, high0);
    end
    clr();
    wave(5, 5, 7);
    checks++;
    if (per_q.size() != 6) begin
      errors++;
      $display("FAIL en_relock_n got %0d want 6", per_q.size());
    end
    for (int k = 0; k < per_q.size(); k++) begin
      checks++;
      if (per_q[k] != 10 || lk_q[k] != ((k >= 4) ? 1 : 0)) begin
        errors++;
        $display("FAIL en_relock[%0d] got %0d/%0d want 10/%0d",
                 k, per_q[k], lk_q[k], (k >= 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_tolerance();
    do_reset();
    clr();
    for (int i = 0; i < 5; i++) begin
      wave(5, 4, 1);
      wave(5, 5, 1);
    end
    checks++;
    if (per_q.size() != 9) begin
      errors++;
      $display("FAIL tol_nvalid got %0d want 9", per_q.size());
    end
    for (int k = 0; k < per_q.size(); k++) begin
      checks++;
      if (per_q[k] != ((k % 2 == 0) ? 9 : 10)) begin
        errors++;
        $display("FAIL tol_period[%0d] got %0d want %0d",
                 k, per_q[k], (k % 2 == 0) ? 9 : 10);
      end
    end
    checks++;
    if (locked1 !== 1'b1) begin
      errors++;
      $display("FAIL tol1_locked got %b want 1", locked1);
    end
    checks++;
    if (locked0 !== 1'b0 || ever0) begin
      errors++;
      $display("FAIL tol0_locked got %b/%b want 0/0",
               locked0, ever0);
    end
  endtask

  initial begin
    test_reset();
    test_div6();
    test_div7_to_8();
    test_overflow();
    test_async_reset();
    test_enable_toggle();
    test_tolerance();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
